jtvigil_prio_colmix: RTL

Parametrised colour mixer and palette unit, the next generation of the Vigilante mixer. It resolves priority across LAYERS pixel planes using per-layer enables and a promotion rule, then reads R, G and B from an internal palette byte RAM with an explicit fetch state machine. The result is blanked, optionally dimmed and driven to the video output. The palette RAM's CPU port runs on the same single clock as the video logic.

---
 rtl/jtvigil_prio_colmix_if.sv | 20 ++
 rtl/jtvigil_prio_colmix.sv | 130 +++++++++++++
 2 files changed

// File: rtl/jtvigil_prio_colmix_if.sv
// Palette CPU bus for jtvigil_prio_colmix.
// master: cpu_addr/cpu_dout/cpu_we out, cpu_din in; slave is the mirror.
interface jtvigil_prio_colmix_if #(
  parameter int PALW = 12
);
  logic [PALW-1:0] cpu_addr;
  logic [7:0]      cpu_dout;
  logic            cpu_we;
  logic [7:0]      cpu_din;

  modport master (
    output cpu_addr, cpu_dout, cpu_we,
    input  cpu_din
  );

  modport slave (
    input  cpu_addr, cpu_dout, cpu_we,
    output cpu_din
  );
endinterface

// File: rtl/jtvigil_prio_colmix.sv
// Layer priority resolver + palette RAM + blank/dim colour output.
// Ports: clk, rst, pxl_cen, LHBL, LVBL, layer_pxl, layer_en,
// promote_en, dim, cpu (palette bus, slave), red, green, blue.
module jtvigil_prio_colmix #(
  parameter int LAYERS = 3,
  parameter int PXLW   = 8,
  parameter int CW     = 5,
  parameter int LW     = 2
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pxl_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  input  logic [LAYERS*PXLW-1:0] layer_pxl,
  input  logic [LAYERS-1:0]      layer_en,
  input  logic [LAYERS-1:0]      promote_en,
  input  logic                   dim,
  jtvigil_prio_colmix_if.slave   cpu,
  output logic [CW-1:0]          red,
  output logic [CW-1:0]          green,
  output logic [CW-1:0]          blue
);
  localparam int PALW = LW + PXLW + 2;

  typedef enum logic [2:0] {
    IDLE, RD_R, RD_G, RD_B, CAP_B
  } state_t;

  state_t          state;
  logic [LW-1:0]   op_k, pr_k, win;
  logic [PXLW-1:0] op_p, pr_p, p_k, win_pxl;
  logic            any_pr;
  logic [PALW-1:0] fetch_addr;
  logic [7:0]      mem [2**PALW];
  logic [7:0]      rd_data;
  logic [CW-1:0]   pre_r, pre_g, pre_b;
  logic            blank;
  logic            unused_bits;

  assign blank = !LHBL || !LVBL;
  assign unused_bits = ^{rd_data, promote_en[LAYERS-1]};

  // Ascending scan: later hits overwrite, so the highest index wins.
  // With nothing opaque, op_* keep layer 0's raw pixel (backdrop).
  always_comb begin
    op_k   = '0;
    op_p   = layer_pxl[PXLW-1:0];
    pr_k   = '0;
    pr_p   = '0;
    any_pr = 1'b0;
    p_k    = '0;
    for (int k = 0; k < LAYERS; k++) begin
      p_k = layer_pxl[k*PXLW +: PXLW];
      if (layer_en[k] && p_k[3:0] != 4'd0) begin
        op_k = LW'(k);
        op_p = p_k;
        if (k < LAYERS-1 && promote_en[k] &&
            p_k[PXLW-1 -: 2] == 2'b11 && p_k[3]) begin
          pr_k   = LW'(k);
          pr_p   = p_k;
          any_pr = 1'b1;
        end
      end
    end
    win     = any_pr ? pr_k : op_k;
    win_pxl = any_pr ? pr_p : op_p;
  end

  function automatic logic [CW-1:0] shade(
    input logic [CW-1:0] v
  );
    if (blank) return '0;
    return dim ? (v >> 1) : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_addr <= '0;
      pre_r      <= '0;
      pre_g      <= '0;
      pre_b      <= '0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
    end else if (pxl_cen) begin
      // A new pixel always restarts the fetch.
      state      <= RD_R;
      fetch_addr <= {win, win_pxl, 2'd0};
      red        <= shade(pre_r);
      green      <= shade(pre_g);
      blue       <= shade(pre_b);
    end else begin
      // rd_data lags fetch_addr by one clk.
      unique case (state)
        IDLE: state <= IDLE;
        RD_R: begin
          state           <= RD_G;
          fetch_addr[1:0] <= 2'd1;
        end
        RD_G: begin
          state           <= RD_B;
          fetch_addr[1:0] <= 2'd2;
          pre_r           <= rd_data[CW-1:0];
        end
        RD_B: begin
          state <= CAP_B;
          pre_g <= rd_data[CW-1:0];
        end
        CAP_B: begin
          state <= IDLE;
          pre_b <= rd_data[CW-1:0];
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-before-write: a same-edge fetch sees the old byte.
  always_ff @(posedge clk) begin
    if (cpu.cpu_we) mem[cpu.cpu_addr] <= cpu.cpu_dout;
    rd_data <= mem[fetch_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cpu.cpu_din <= '0;
    else     cpu.cpu_din <= mem[cpu.cpu_addr];
  end
endmodule
